// File: rtl/lsu_io_req_ctrl.sv
// Purpose : non-speculative controller for uncached IO loads/stores. One access in flight at a time,
//           issued on the IO bus only once it is the ROB head.
// Latency : accept -> done pulse in 4 cycles minimum; +1 per bus rdy-low cycle or response-delay cycle.
// Backpr. : lsq_io_req_rdy_o only while IDLE and not flushing; the bus request is held until io_bus_req_rdy_i.
// Ports   : clk/rst (sync, active-high); flush; LSQ request (vld/rdy, is_ld, paddr, size, wdata, rob_tag);
//           ROB head (vld, tag); IO bus request (vld/rdy, we, paddr, size, wdata, wstrb);
//           IO bus response (vld, err, rdata); LSQ completion (vld pulse, rob_tag, err, rdata); io_busy_o.
// Option  : define LSU_IO_TIMEOUT_EN to end a silent response wait after TIMEOUT_CYCLES with err = 1.
module lsu_io_req_ctrl #(
  parameter int PADDR_W        = 56,
  parameter int XLEN           = 64,
  parameter int ROB_TAG_W      = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 lsq_io_req_vld_i,
  output logic                 lsq_io_req_rdy_o,
  input  logic                 lsq_io_req_is_ld_i,
  input  logic [PADDR_W-1:0]   lsq_io_req_paddr_i,
  input  logic [1:0]           lsq_io_req_size_i,
  input  logic [XLEN-1:0]      lsq_io_req_wdata_i,
  input  logic [ROB_TAG_W-1:0] lsq_io_req_rob_tag_i,
  input  logic                 rob_head_vld_i,
  input  logic [ROB_TAG_W-1:0] rob_head_tag_i,
  output logic                 io_bus_req_vld_o,
  input  logic                 io_bus_req_rdy_i,
  output logic                 io_bus_req_we_o,
  output logic [PADDR_W-1:0]   io_bus_req_paddr_o,
  output logic [1:0]           io_bus_req_size_o,
  output logic [XLEN-1:0]      io_bus_req_wdata_o,
  output logic [XLEN/8-1:0]    io_bus_req_wstrb_o,
  input  logic                 io_bus_resp_vld_i,
  input  logic                 io_bus_resp_err_i,
  input  logic [XLEN-1:0]      io_bus_resp_rdata_i,
  output logic                 io_lsq_done_vld_o,
  output logic [ROB_TAG_W-1:0] io_lsq_done_rob_tag_o,
  output logic                 io_lsq_done_err_o,
  output logic [XLEN-1:0]      io_lsq_done_rdata_o,
  output logic                 io_busy_o
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HEAD,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  is_ld_q, is_ld_d;
  logic [PADDR_W-1:0]    paddr_q, paddr_d;
  logic [1:0]            size_q, size_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [ROB_TAG_W-1:0]  tag_q, tag_d;
  // Completion fields live in their own registers so they hold after the pulse,
  // even once the next access has overwritten the request registers.
  logic [ROB_TAG_W-1:0]  done_tag_q, done_tag_d;
  logic                  done_err_q, done_err_d;
  logic [XLEN-1:0]       done_rdata_q, done_rdata_d;

`ifdef LSU_IO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`else
  logic                  unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Lane formatting, all derived from the captured request.
  logic [OFF_W-1:0]      off;
  logic [OFF_W+2:0]      shift_bits;
  logic                  misaligned;
  logic [STRB_W-1:0]     byte_mask;
  logic [XLEN-1:0]       rd_mask;
  logic [XLEN-1:0]       resp_fmt;
  logic                  in_req;

  always_comb begin
    off        = paddr_q[OFF_W-1:0];
    shift_bits = {off, 3'b000};
    misaligned = 1'b0;
    byte_mask  = '0;
    rd_mask    = '0;
    case (size_q)
      2'd0: begin
        misaligned = 1'b0;
        byte_mask  = STRB_W'(1);
        rd_mask    = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      2'd1: begin
        misaligned = paddr_q[0];
        byte_mask  = STRB_W'(3);
        rd_mask    = {{(XLEN-16){1'b0}}, 16'hFFFF};
      end
      2'd2: begin
        misaligned = |paddr_q[1:0];
        byte_mask  = STRB_W'(15);
        rd_mask    = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: begin
        misaligned = |paddr_q[2:0];
        byte_mask  = '1;
        rd_mask    = '1;
      end
    endcase
    resp_fmt = (io_bus_resp_rdata_i >> shift_bits) & rd_mask;
  end

  // Bus fields are forced to zero outside REQ; inside REQ they come straight from
  // registers and therefore stay stable until the request is taken.
  assign in_req             = (state_q == S_REQ);
  assign io_bus_req_vld_o   = in_req;
  assign io_bus_req_we_o    = in_req & ~is_ld_q;
  assign io_bus_req_paddr_o = in_req ? paddr_q : '0;
  assign io_bus_req_size_o  = in_req ? size_q : 2'd0;
  assign io_bus_req_wdata_o = in_req ? (wdata_q << shift_bits) : '0;
  assign io_bus_req_wstrb_o = in_req ? (byte_mask << off) : '0;

  assign lsq_io_req_rdy_o      = (state_q == S_IDLE) & ~flush;
  assign io_lsq_done_vld_o     = (state_q == S_DONE) & ~kill_q & ~flush;
  assign io_lsq_done_rob_tag_o = done_tag_q;
  assign io_lsq_done_err_o     = done_err_q;
  assign io_lsq_done_rdata_o   = done_rdata_q;
  assign io_busy_o             = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    is_ld_d      = is_ld_q;
    paddr_d      = paddr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    done_tag_d   = done_tag_q;
    done_err_d   = done_err_q;
    done_rdata_d = done_rdata_q;
`ifdef LSU_IO_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsq_io_req_vld_i && !flush) begin
          is_ld_d = lsq_io_req_is_ld_i;
          paddr_d = lsq_io_req_paddr_i;
          size_d  = lsq_io_req_size_i;
          wdata_d = lsq_io_req_wdata_i;
          tag_d   = lsq_io_req_rob_tag_i;
          kill_d  = 1'b0;
          state_d = S_WAIT_HEAD;
        end
      end
      S_WAIT_HEAD: begin
        // Not yet issued, so a flush can drop the access silently.
        if (flush) begin
          state_d = S_IDLE;
        end else if (rob_head_vld_i && (rob_head_tag_i == tag_q)) begin
          if (misaligned) begin
            state_d      = S_DONE;
            done_tag_d   = tag_q;
            done_err_d   = 1'b1;
            done_rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // The request cannot be retracted; a flush only suppresses the completion.
        if (flush) kill_d = 1'b1;
        if (io_bus_req_rdy_i) begin
          state_d  = S_RESP;
`ifdef LSU_IO_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_RESP: begin
        if (flush) kill_d = 1'b1;
        if (io_bus_resp_vld_i) begin
          state_d      = S_DONE;
          done_tag_d   = tag_q;
          done_err_d   = io_bus_resp_err_i;
          done_rdata_d = is_ld_q ? resp_fmt : '0;
        end
`ifdef LSU_IO_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = S_DONE;
          done_tag_d   = tag_q;
          done_err_d   = 1'b1;
          done_rdata_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kill_q       <= 1'b0;
      is_ld_q      <= 1'b0;
      paddr_q      <= '0;
      size_q       <= 2'd0;
      wdata_q      <= '0;
      tag_q        <= '0;
      done_tag_q   <= '0;
      done_err_q   <= 1'b0;
      done_rdata_q <= '0;
`ifdef LSU_IO_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      is_ld_q      <= is_ld_d;
      paddr_q      <= paddr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      done_tag_q   <= done_tag_d;
      done_err_q   <= done_err_d;
      done_rdata_q <= done_rdata_d;
`ifdef LSU_IO_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_io_req_ctrl.sv
// Purpose : self-checking bench for lsu_io_req_ctrl; each access is described as a timeline
//           (head wait, bus stall, response delay, flush point) from which all outputs are predicted.
// Latency : n/a (bench).
// Backpr. : drives io_bus_req_rdy_i low for a chosen number of REQ cycles.
module tb_lsu_io_req_ctrl;
  localparam int TO = 8;
`ifdef LSU_IO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst, flush;
  logic        lsq_io_req_vld_i, lsq_io_req_rdy_o, lsq_io_req_is_ld_i;
  logic [55:0] lsq_io_req_paddr_i;
  logic [1:0]  lsq_io_req_size_i;
  logic [63:0] lsq_io_req_wdata_i;
  logic [5:0]  lsq_io_req_rob_tag_i;
  logic        rob_head_vld_i;
  logic [5:0]  rob_head_tag_i;
  logic        io_bus_req_vld_o, io_bus_req_rdy_i, io_bus_req_we_o;
  logic [55:0] io_bus_req_paddr_o;
  logic [1:0]  io_bus_req_size_o;
  logic [63:0] io_bus_req_wdata_o;
  logic [7:0]  io_bus_req_wstrb_o;
  logic        io_bus_resp_vld_i, io_bus_resp_err_i;
  logic [63:0] io_bus_resp_rdata_i;
  logic        io_lsq_done_vld_o;
  logic [5:0]  io_lsq_done_rob_tag_o;
  logic        io_lsq_done_err_o;
  logic [63:0] io_lsq_done_rdata_o;
  logic        io_busy_o;

  lsu_io_req_ctrl #(.PADDR_W(56), .XLEN(64), .ROB_TAG_W(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsq_io_req_vld_i(lsq_io_req_vld_i), .lsq_io_req_rdy_o(lsq_io_req_rdy_o),
    .lsq_io_req_is_ld_i(lsq_io_req_is_ld_i), .lsq_io_req_paddr_i(lsq_io_req_paddr_i),
    .lsq_io_req_size_i(lsq_io_req_size_i), .lsq_io_req_wdata_i(lsq_io_req_wdata_i),
    .lsq_io_req_rob_tag_i(lsq_io_req_rob_tag_i),
    .rob_head_vld_i(rob_head_vld_i), .rob_head_tag_i(rob_head_tag_i),
    .io_bus_req_vld_o(io_bus_req_vld_o), .io_bus_req_rdy_i(io_bus_req_rdy_i),
    .io_bus_req_we_o(io_bus_req_we_o), .io_bus_req_paddr_o(io_bus_req_paddr_o),
    .io_bus_req_size_o(io_bus_req_size_o), .io_bus_req_wdata_o(io_bus_req_wdata_o),
    .io_bus_req_wstrb_o(io_bus_req_wstrb_o),
    .io_bus_resp_vld_i(io_bus_resp_vld_i), .io_bus_resp_err_i(io_bus_resp_err_i),
    .io_bus_resp_rdata_i(io_bus_resp_rdata_i),
    .io_lsq_done_vld_o(io_lsq_done_vld_o), .io_lsq_done_rob_tag_o(io_lsq_done_rob_tag_o),
    .io_lsq_done_err_o(io_lsq_done_err_o), .io_lsq_done_rdata_o(io_lsq_done_rdata_o),
    .io_busy_o(io_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle expectations published by the driver, checked on the falling edge.
  bit          chk_on = 1'b0;
  bit          e_rdy, e_busy, e_bvld, e_we, e_dvld, e_derr;
  logic [55:0] e_pa;
  logic [1:0]  e_sz;
  logic [63:0] e_wd, e_rd;
  logic [7:0]  e_strb;
  logic [5:0]  e_tag;
  int          cur_t;

  // Observations used by the hand-computed literal checks.
  int          obs_done_t, obs_req_cycles;
  logic [63:0] obs_rd, obs_wd;
  logic [7:0]  obs_strb;
  logic        obs_err;
  logic [5:0]  obs_tag;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_rdy", 64'(lsq_io_req_rdy_o), 64'(e_rdy));
      chk("busy", 64'(io_busy_o), 64'(e_busy));
      chk("bus_vld", 64'(io_bus_req_vld_o), 64'(e_bvld));
      if (e_bvld && io_bus_req_vld_o) begin
        chk("bus_we", 64'(io_bus_req_we_o), 64'(e_we));
        chk("bus_paddr", 64'(io_bus_req_paddr_o), 64'(e_pa));
        chk("bus_size", 64'(io_bus_req_size_o), 64'(e_sz));
        chk("bus_wdata", io_bus_req_wdata_o, e_wd);
        chk("bus_wstrb", 64'(io_bus_req_wstrb_o), 64'(e_strb));
      end
      chk("done_vld", 64'(io_lsq_done_vld_o), 64'(e_dvld));
      if (e_dvld && io_lsq_done_vld_o) begin
        chk("done_tag", 64'(io_lsq_done_rob_tag_o), 64'(e_tag));
        chk("done_err", 64'(io_lsq_done_err_o), 64'(e_derr));
        chk("done_rdata", io_lsq_done_rdata_o, e_rd);
      end
      if (io_bus_req_vld_o) begin
        obs_req_cycles++;
        obs_wd   = io_bus_req_wdata_o;
        obs_strb = io_bus_req_wstrb_o;
      end
      if (io_lsq_done_vld_o) begin
        obs_done_t = cur_t;
        obs_rd     = io_lsq_done_rdata_o;
        obs_err    = io_lsq_done_err_o;
        obs_tag    = io_lsq_done_rob_tag_o;
      end
    end
  end

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_req_fields();
    lsq_io_req_is_ld_i   = 1'($urandom_range(0, 1));
    lsq_io_req_paddr_i   = 56'(r64());
    lsq_io_req_size_i    = 2'($urandom_range(0, 3));
    lsq_io_req_wdata_i   = r64();
    lsq_io_req_rob_tag_i = 6'($urandom_range(0, 63));
  endtask

  task automatic clear_obs();
    obs_done_t     = -1;
    obs_req_cycles = 0;
    obs_err        = 1'b0;
    obs_rd         = '0;
  endtask

  // One access, relative cycle t = 0 is the offer/accept cycle.
  // hd: head-mismatch cycles, rd: bus rdy-low cycles, dd: response delay after entering RESP.
  // fmode: 0 none, 1 flush while waiting for head, 2 flush in REQ, 3 flush in RESP,
  //        4 flush in the done cycle, 6 reset while in REQ.
  task automatic run_txn(input bit is_ld, input logic [55:0] pa, input logic [1:0] sz,
                         input logic [63:0] wd, input logic [5:0] tag, input int hd,
                         input int rd, input int dd, input logic [63:0] rdat, input bit rerr,
                         input int fmode_in, input int fofs);
    int          off, wait_end, r0, r1, s0, s1, done, last, fcyc, rcyc, rlo, rhi, fmode;
    bit          mis, has_req, killed, has_done, eerr;
    logic [63:0] ewd, erd, mask;
    logic [15:0] strb16;
    fmode  = fmode_in;
    off    = int'(pa[2:0]);
    mis    = (pa & ((56'd1 << sz) - 56'd1)) != 56'd0;
    if (mis && (fmode == 2 || fmode == 3 || fmode == 6)) fmode = 0;
    ewd    = wd << (8 * off);
    strb16 = ((16'd1 << (1 << sz)) - 16'd1) << off;
    mask   = (sz == 2'd3) ? '1 : ((64'd1 << (8 << sz)) - 64'd1);
    erd    = is_ld ? ((rdat >> (8 * off)) & mask) : 64'd0;
    wait_end = 1 + hd;
    r0 = -1; r1 = -1; s0 = -1; s1 = -1; done = -1; fcyc = -1; rcyc = -1;
    has_req = 1'b0; eerr = 1'b0;
    if (fmode == 1) begin
      last = wait_end; fcyc = wait_end;
    end else if (mis) begin
      done = wait_end + 1; last = done; eerr = 1'b1; erd = '0;
    end else begin
      has_req = 1'b1; r0 = wait_end + 1; r1 = r0 + rd; s0 = r1 + 1;
      if (fmode == 6) begin
        rcyc = r0; r1 = r0; s0 = -1; last = r0;
      end else if (TO_EN && dd > TO - 1) begin
        done = s0 + TO; eerr = 1'b1; erd = '0; last = done;
      end else begin
        s1 = s0 + dd; done = s1 + 1; eerr = rerr; last = done;
      end
    end
    if (fmode == 2) fcyc = r0 + (fofs % (rd + 1));
    if (fmode == 3) fcyc = s0 + (fofs % (done - s0));
    if (fmode == 4) fcyc = done;
    killed   = (fmode == 2 || fmode == 3 || fmode == 4);
    has_done = (done >= 0) && !killed;
    rlo = s0;
    rhi = (s1 >= 0) ? s1 : done - 1;
    for (int t = 0; t <= last + 1; t++) begin
      @(posedge clk);
      #1;
      cur_t            = t;
      rst              = (t == rcyc);
      flush            = (t == fcyc);
      lsq_io_req_vld_i = (t == 0);
      if (t == 0) begin
        lsq_io_req_is_ld_i   = is_ld;
        lsq_io_req_paddr_i   = pa;
        lsq_io_req_size_i    = sz;
        lsq_io_req_wdata_i   = wd;
        lsq_io_req_rob_tag_i = tag;
      end else begin
        rand_req_fields();
      end
      if (fmode != 1 && t >= wait_end) begin
        rob_head_vld_i = 1'b1; rob_head_tag_i = tag;
      end else if ($urandom_range(0, 1) == 0) begin
        rob_head_vld_i = 1'b0; rob_head_tag_i = tag;
      end else begin
        rob_head_vld_i = 1'b1; rob_head_tag_i = tag ^ 6'($urandom_range(1, 63));
      end
      if (has_req && t >= r0 && t < r1)  io_bus_req_rdy_i = 1'b0;
      else if (has_req && t == r1)       io_bus_req_rdy_i = 1'b1;
      else                               io_bus_req_rdy_i = 1'($urandom_range(0, 1));
      if (t == s1) begin
        io_bus_resp_vld_i = 1'b1; io_bus_resp_err_i = rerr; io_bus_resp_rdata_i = rdat;
      end else begin
        // Stray responses outside RESP must be ignored.
        io_bus_resp_vld_i   = (s0 >= 0 && t >= rlo && t <= rhi) ? 1'b0 : ($urandom_range(0, 3) == 0);
        io_bus_resp_err_i   = 1'($urandom_range(0, 1));
        io_bus_resp_rdata_i = r64();
      end
      e_busy = (t >= 1 && t <= last);
      e_rdy  = !e_busy && !flush;
      e_bvld = has_req && t >= r0 && t <= r1;
      e_we   = !is_ld; e_pa = pa; e_sz = sz; e_wd = ewd; e_strb = strb16[7:0];
      e_dvld = has_done && t == done;
      e_tag  = tag; e_derr = eerr; e_rd = erd;
      chk_on = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit v, input bit f);
    @(posedge clk);
    #1;
    cur_t = 0; rst = 1'b0; flush = f; lsq_io_req_vld_i = v;
    rand_req_fields();
    rob_head_vld_i = 1'($urandom_range(0, 1)); rob_head_tag_i = 6'($urandom_range(0, 63));
    io_bus_req_rdy_i = 1'($urandom_range(0, 1)); io_bus_resp_vld_i = 1'($urandom_range(0, 1));
    io_bus_resp_err_i = 1'b0; io_bus_resp_rdata_i = r64();
    e_busy = 1'b0; e_rdy = !f; e_bvld = 1'b0; e_dvld = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [55:0] pa;
    int          fm;
    rst = 1'b1; flush = 1'b0; lsq_io_req_vld_i = 1'b0;
    lsq_io_req_is_ld_i = 1'b0; lsq_io_req_paddr_i = '0; lsq_io_req_size_i = '0;
    lsq_io_req_wdata_i = '0; lsq_io_req_rob_tag_i = '0;
    rob_head_vld_i = 1'b0; rob_head_tag_i = '0; io_bus_req_rdy_i = 1'b0;
    io_bus_resp_vld_i = 1'b0; io_bus_resp_err_i = 1'b0; io_bus_resp_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(lsq_io_req_rdy_o), 64'd1);
    chk("rst_busy", 64'(io_busy_o), 64'd0);
    chk("rst_bus_vld", 64'(io_bus_req_vld_o), 64'd0);
    chk("rst_bus_we", 64'(io_bus_req_we_o), 64'd0);
    chk("rst_bus_paddr", 64'(io_bus_req_paddr_o), 64'd0);
    chk("rst_bus_size", 64'(io_bus_req_size_o), 64'd0);
    chk("rst_bus_wdata", io_bus_req_wdata_o, 64'd0);
    chk("rst_bus_wstrb", 64'(io_bus_req_wstrb_o), 64'd0);
    chk("rst_done_vld", 64'(io_lsq_done_vld_o), 64'd0);
    chk("rst_done_tag", 64'(io_lsq_done_rob_tag_o), 64'd0);
    chk("rst_done_err", 64'(io_lsq_done_err_o), 64'd0);
    chk("rst_done_rdata", io_lsq_done_rdata_o, 64'd0);
    #1;
    rst = 1'b0;

    // LB at 0x1000_0003: byte 3 of the beat.
    clear_obs();
    run_txn(1'b1, 56'h1000_0003, 2'd0, r64(), 6'h15, 0, 0, 0, 64'h0000_0000_AB00_0000, 1'b0, 0, 0);
    chk("lb_done_cycle", 64'(obs_done_t), 64'd4);
    chk("lb_rdata", obs_rd, 64'hAB);
    chk("lb_err", 64'(obs_err), 64'd0);
    chk("lb_tag", 64'(obs_tag), 64'h15);

    // SH at 0x1000_0006 with three stalled request cycles.
    clear_obs();
    run_txn(1'b0, 56'h1000_0006, 2'd1, 64'h1234, 6'h2A, 0, 3, 0, r64(), 1'b0, 0, 0);
    chk("sh_wstrb", 64'(obs_strb), 64'hC0);
    chk("sh_wdata", obs_wd, 64'h1234_0000_0000_0000);
    chk("sh_req_cycles", 64'(obs_req_cycles), 64'd4);
    chk("sh_done_cycle", 64'(obs_done_t), 64'd7);
    chk("sh_rdata", obs_rd, 64'd0);

    // Head mismatches for 5 cycles then flush: nothing issued, nothing completed.
    clear_obs();
    run_txn(1'b1, 56'h2000_0010, 2'd2, r64(), 6'h07, 5, 0, 0, r64(), 1'b0, 1, 0);
    chk("headflush_req_cycles", 64'(obs_req_cycles), 64'd0);
    chk("headflush_done", 64'(obs_done_t), 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush in RESP, response 10 cycles later: completion suppressed.
    clear_obs();
    run_txn(1'b1, 56'h40, 2'd3, r64(), 6'h11, 0, 0, 10, r64(), 1'b0, 3, 2);
    chk("respflush_done", 64'(obs_done_t), 64'hFFFF_FFFF_FFFF_FFFF);

    // Misaligned LW at 0x2: error without a bus access.
    clear_obs();
    run_txn(1'b1, 56'h2, 2'd2, r64(), 6'h3C, 0, 0, 0, r64(), 1'b0, 0, 0);
    chk("mis_req_cycles", 64'(obs_req_cycles), 64'd0);
    chk("mis_err", 64'(obs_err), 64'd1);
    chk("mis_done_cycle", 64'(obs_done_t), 64'd2);

    // Bus error response.
    clear_obs();
    run_txn(1'b1, 56'h8, 2'd3, r64(), 6'h01, 0, 0, 2, 64'hDEAD_BEEF_0000_0001, 1'b1, 0, 0);
    chk("buserr_err", 64'(obs_err), 64'd1);

    // Silent bus: timeout (when enabled) or a long wait otherwise.
    clear_obs();
    run_txn(1'b1, 56'h10, 2'd2, r64(), 6'h22, 0, 0, 40, 64'h0000_0000_5555_AAAA, 1'b0, 0, 0);
    chk("silent_done_cycle", 64'(obs_done_t), TO_EN ? 64'd11 : 64'd44);
    chk("silent_err", 64'(obs_err), TO_EN ? 64'd1 : 64'd0);

    // Offer together with flush in IDLE must not be accepted.
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b0, 1'b0);

    // Reset while the request is on the bus.
    run_txn(1'b0, 56'h100, 2'd3, r64(), 6'h09, 1, 2, 0, r64(), 1'b0, 6, 0);

    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      pa = 56'(r64());
      if ($urandom_range(0, 4) != 0) pa = pa & ~((56'd1 << sz) - 56'd1);
      case ($urandom_range(0, 9))
        0: fm = 1;
        1: fm = 2;
        2: fm = 3;
        3: fm = 4;
        4: fm = ($urandom_range(0, 2) == 0) ? 6 : 0;
        default: fm = 0;
      endcase
      run_txn(1'($urandom_range(0, 1)), pa, sz, r64(), 6'($urandom_range(0, 63)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6), r64(),
              1'($urandom_range(0, 1)), fm, $urandom_range(0, 6));
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_io_req_ctrl.md
# lsu_io_req_ctrl

Non-speculative controller for uncached IO accesses. It sits downstream of the LSU PMA check: once the LSQ has marked an access as IO, it hands that access here. The block holds the access until it reaches the ROB head, then issues it as a single-beat request on the IO bus. It returns load data, or a store acknowledge, to the LSQ. Only one IO access is in flight at a time, so IO accesses stay strongly ordered.

## Interface
Parameters:
- PADDR_W, 56, physical address width
- XLEN, 64, data width; XLEN/8 byte strobes
- ROB_TAG_W, 6, ROB tag width
- TIMEOUT_CYCLES, 1024, response timeout (only with LSU_IO_TIMEOUT_EN)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; kills a non-issued access
- lsq_io_req_vld_i  in  1  IO access offered
- lsq_io_req_rdy_o  out  1  block can accept an access
- lsq_io_req_is_ld_i  in  1  1 = load, 0 = store
- lsq_io_req_paddr_i  in  PADDR_W  physical address
- lsq_io_req_size_i  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D
- lsq_io_req_wdata_i  in  XLEN  store data, LSB-aligned
- lsq_io_req_rob_tag_i  in  ROB_TAG_W  ROB tag of the access
- rob_head_vld_i  in  1  ROB head is valid
- rob_head_tag_i  in  ROB_TAG_W  ROB head tag
- io_bus_req_vld_o  out  1  bus request valid
- io_bus_req_rdy_i  in  1  bus accepts request
- io_bus_req_we_o  out  1  write
- io_bus_req_paddr_o  out  PADDR_W  address
- io_bus_req_size_o  out  2  size
- io_bus_req_wdata_o  out  XLEN  byte-lane-shifted store data
- io_bus_req_wstrb_o  out  XLEN/8  byte strobes
- io_bus_resp_vld_i  in  1  response valid
- io_bus_resp_err_i  in  1  bus error
- io_bus_resp_rdata_i  in  XLEN  read data, lane-aligned
- io_lsq_done_vld_o  out  1  one-cycle completion pulse
- io_lsq_done_rob_tag_o  out  ROB_TAG_W  tag of the completed access
- io_lsq_done_err_o  out  1  access fault
- io_lsq_done_rdata_o  out  XLEN  load data, right-shifted to bit 0, zero-extended per size
- io_busy_o  out  1  state != IDLE

## Operation
- States: IDLE, WAIT_HEAD, REQ, RESP, DONE.
- IDLE:
  - lsq_io_req_rdy_o = ~flush.
  - On vld & rdy: capture all request fields, clear kill, go to WAIT_HEAD.
- WAIT_HEAD:
  - On flush: go to IDLE with no completion pulse.
  - Else, when rob_head_vld_i and rob_head_tag_i == stored tag:
    - misaligned (paddr not a multiple of 2^size): go to DONE with err = 1 and no bus access;
    - aligned: go to REQ.
- REQ:
  - Drive io_bus_req_vld_o = 1 with stable fields until io_bus_req_rdy_i, then go to RESP.
  - A request must never be retracted. A flush here only sets kill.
- RESP:
  - On io_bus_resp_vld_i: capture err and data, go to DONE.
  - A flush here sets kill.
- DONE:
  - io_lsq_done_vld_o = ~kill & ~flush, then go to IDLE.
  - Done fields are driven from registers.
- Store formatting:
  - wstrb = ((1 << (1 << size)) - 1) << paddr[2:0].
  - wdata = wdata_i << (8 * paddr[2:0]).
- Load formatting:
  - rdata_o = (rdata_i >> (8 * paddr[2:0])), masked to 8 << size bits.
  - Sign extension is done by the LSQ.
- For stores, io_lsq_done_rdata_o = 0.
- io_bus_resp_vld_i is ignored outside RESP.

## Timing
- Reset:
  - all outputs 0, except lsq_io_req_rdy_o = 1;
  - state IDLE, kill 0.
  - Reset mid-transaction abandons the transaction; the bus is reset with the core.
- Minimum latency, from accept (cycle 0) with the head already matching, to the done pulse at cycle 4:
  - WAIT_HEAD at cycle 1;
  - REQ at cycle 2 with bus rdy = 1;
  - RESP at cycle 3 with resp the same cycle;
  - DONE at cycle 4.
- Each cycle of bus back-pressure or response delay adds one cycle.
- Flush in IDLE together with req_vld: the access is not accepted.
- Done-pulse fields are valid only during the pulse; otherwise they hold their last value.

## Configuration
- LSU_IO_TIMEOUT_EN defined:
  - a counter clears on entry to RESP and increments each RESP cycle;
  - when it reaches TIMEOUT_CYCLES - 1 with no response, go to DONE with err = 1.
  - The system guarantees no late response after a timeout.
- Undefined:
  - no counter; RESP waits indefinitely.

## Test plan
- Load: LB at paddr 0x1000_0003, head matches, bus returns rdata 0x00000000_AB000000 -> done pulse at cycle 4, rdata 0xAB, err 0, tag echoed.
- Store: SH at 0x1000_0006, wdata 0x1234 -> wstrb 0xC0, wdata 0x1234_0000_0000_0000, we 1; request held 3 cycles under rdy = 0; done, rdata 0.
- Head wait with flush: head tag mismatches for 5 cycles, then flush -> no bus request, no done pulse, rdy = 1 next cycle.
- Flush during RESP, response after 10 cycles -> no done pulse; IDLE after the response. A misaligned LW at 0x2 -> err done, no bus request.
- Error and timeout: resp_err = 1 -> done with err 1. With LSU_IO_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no response -> err done exactly 8 cycles after entering RESP.
